// File: rtl/fpu_normalize_round.sv
// Normalizes a 49-bit adder sum and rounds it to an IEEE-754 single-precision result.
// Latency: out_valid rises on the third rising edge counting the accepting edge (IDLE->NORM->ROUND->DONE).
// Backpressure: the result is held in DONE until out_ready; in_ready is low outside IDLE.
module fpu_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [48:0] in_sum,
    input  logic        in_sign,
    input  logic        in_eff_sub,
    input  logic        in_sticky,
    input  logic [9:0]  in_exp,
    input  logic [2:0]  in_rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    logic [1:0]         r_state;
    logic [48:0]        r_sum;
    logic               r_sign;
    logic               r_eff_sub;
    logic               r_sticky;
    logic [9:0]         r_exp;
    logic [2:0]         r_rm;
    logic [47:0]        r_norm;
    logic               r_nsticky;
    logic signed [10:0] r_e;
    logic [31:0]        r_result;
    logic [4:0]         r_flags;

    logic [5:0]         w_lz;
    logic [47:0]        w_norm;
    logic               w_nsticky;
    logic signed [10:0] w_e;

    logic               w_g;
    logic               w_r;
    logic               w_s;
    logic               w_nx;
    logic               w_inc;
    logic [24:0]        w_mant_inc;
    logic [22:0]        w_frac;
    logic signed [10:0] w_e_fin;
    logic [31:0]        w_result;
    logic [4:0]         w_flags;

    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_flags  = r_flags;

    // Leading-zero count from bit 47 and normalization shift of the captured sum
    always_comb begin
        w_lz = 6'd0;
        for (int i = 0; i <= 47; i++) begin
            if (r_sum[i]) w_lz = 6'(47 - i);
        end
        if (r_sum[48]) begin
            w_norm    = r_sum[48:1];
            w_nsticky = r_sticky | r_sum[0];
            w_e       = $signed({1'b0, r_exp}) + 11'sd1;
        end else begin
            w_norm    = r_sum[47:0] << w_lz;
            w_nsticky = r_sticky;
            w_e       = $signed({1'b0, r_exp}) - $signed({5'b0, w_lz});
        end
    end

    // Rounding decision, mantissa increment and special-case result selection
    always_comb begin
        w_g  = r_norm[23];
        w_r  = r_norm[22];
        w_s  = (|r_norm[21:0]) | r_nsticky;
        w_nx = w_g | w_r | w_s;
        case (r_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_sign & w_nx;
            RM_RUP:  w_inc = !r_sign & w_nx;
            RM_RMM:  w_inc = w_g;
            default: w_inc = w_g & (w_r | w_s | r_norm[24]);
        endcase
        w_mant_inc = {1'b0, r_norm[47:24]} + 25'(w_inc);
        // All-ones mantissa rolling over becomes 1.0 with the exponent bumped
        if (w_mant_inc[24]) begin
            w_frac  = 23'd0;
            w_e_fin = r_e + 11'sd1;
        end else begin
            w_frac  = w_mant_inc[22:0];
            w_e_fin = r_e;
        end

        if ((r_sum == 49'd0) && !r_sticky) begin
            // Exact zero: cancellation yields -0 only when rounding down
            w_result = {(r_eff_sub ? (r_rm == RM_RDN) : r_sign), 31'd0};
            w_flags  = 5'b00000;
        end else if ((r_sum == 49'd0) || (w_e_fin <= 11'sd0)) begin
            // Flush-to-zero
            w_result = {r_sign, 31'd0};
            w_flags  = 5'b00011;
        end else if (w_e_fin >= 11'sd255) begin
            w_flags = 5'b00101;
            case (r_rm)
                RM_RTZ:  w_result = {r_sign, 31'h7F7FFFFF};
                RM_RDN:  w_result = r_sign ? 32'hFF800000 : 32'h7F7FFFFF;
                RM_RUP:  w_result = r_sign ? 32'hFF7FFFFF : 32'h7F800000;
                default: w_result = {r_sign, 31'h7F800000};
            endcase
        end else begin
            w_result = {r_sign, w_e_fin[7:0], w_frac};
            w_flags  = {4'b0000, w_nx};
        end
    end

    // Control FSM: one operation in flight, four cycles per operation minimum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid && in_ready) r_state <= S_NORM;
                S_NORM:  r_state <= S_ROUND;
                S_ROUND: r_state <= S_DONE;
                default: if (out_ready) r_state <= S_IDLE;
            endcase
        end
    end

    // Input capture on acceptance only; inputs are ignored otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum     <= 49'd0;
            r_sign    <= 1'b0;
            r_eff_sub <= 1'b0;
            r_sticky  <= 1'b0;
            r_exp     <= 10'd0;
            r_rm      <= 3'd0;
        end else if (in_valid && in_ready) begin
            r_sum     <= in_sum;
            r_sign    <= in_sign;
            r_eff_sub <= in_eff_sub;
            r_sticky  <= in_sticky;
            r_exp     <= in_exp;
            r_rm      <= in_rm;
        end
    end

    // Normalized mantissa, sticky and exponent registered in NORM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_norm    <= 48'd0;
            r_nsticky <= 1'b0;
            r_e       <= 11'sd0;
        end else if (r_state == S_NORM) begin
            r_norm    <= w_norm;
            r_nsticky <= w_nsticky;
            r_e       <= w_e;
        end
    end

    // Result registered in ROUND and held stable through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 32'd0;
            r_flags  <= 5'd0;
        end else if (r_state == S_ROUND) begin
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Scoreboard bench: a driver pushes expected results, a monitor pops and compares on each handshake.
module tb_fpu_normalize_round;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] in_sum;
    logic        in_sign;
    logic        in_eff_sub;
    logic        in_sticky;
    logic [9:0]  in_exp;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    fpu_normalize_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_sign    (in_sign),
        .in_eff_sub (in_eff_sub),
        .in_sticky  (in_sticky),
        .in_exp     (in_exp),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          bp_hold = 1'b0;
    logic [36:0] exp_q[$];
    int          acc_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: random unless the bench is forcing backpressure
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: value = sum * 2^(exp-127-47); round the integer sum to 24 significant bits
    function automatic logic [36:0] ref_model(input logic [48:0] sum, input logic sign,
                                             input logic eff_sub, input logic sticky,
                                             input logic [9:0] expn, input logic [2:0] rm_in);
        logic [63:0] s, q, rem, half;
        int          p, sh, e;
        bit          inx, up;
        logic [2:0]  m;
        logic [7:0]  e8;
        logic [31:0] res;
        m = (rm_in > 3'd4) ? 3'd0 : rm_in;
        if (sum == 49'd0 && !sticky) return {5'b00000, (eff_sub ? (m == 3'd2) : sign), 31'd0};
        if (sum == 49'd0) return {5'b00011, sign, 31'd0};
        p = 0;
        for (int i = 0; i < 49; i++) if (sum[i]) p = i;
        e = int'(expn) + p - 47;
        s = 64'(sum);
        if (p > 23) begin
            sh   = p - 23;
            q    = s >> sh;
            rem  = s - (q << sh);
            half = 64'd1 << (sh - 1);
        end else begin
            q    = s << (23 - p);
            rem  = 64'd0;
            half = 64'd1;
        end
        inx = (rem != 0) || sticky;
        case (m)
            3'd0:    up = (rem > half) || (rem == half && (sticky || q[0]));
            3'd1:    up = 1'b0;
            3'd2:    up = sign && inx;
            3'd3:    up = !sign && inx;
            default: up = (rem >= half);
        endcase
        if (up) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) begin
            case (m)
                3'd1:    res = {sign, 31'h7F7FFFFF};
                3'd2:    res = sign ? 32'hFF800000 : 32'h7F7FFFFF;
                3'd3:    res = sign ? 32'hFF7FFFFF : 32'h7F800000;
                default: res = {sign, 31'h7F800000};
            endcase
            return {5'b00101, res};
        end
        if (e <= 0) return {5'b00011, sign, 31'd0};
        e8 = e[7:0];
        return {4'b0000, inx, sign, e8, q[22:0]};
    endfunction

    task automatic send(input logic [48:0] s, input logic sg, input logic eff, input logic st,
                        input logic [9:0] e, input logic [2:0] rm, input logic [36:0] expv,
                        input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
            return;
        end
        in_sum = s; in_sign = sg; in_eff_sub = eff; in_sticky = st; in_exp = e; in_rm = rm;
        in_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        if (push) acc_q.push_back(cyc);
        in_valid = 1'b0;
        // Garbage on the inputs after acceptance must not disturb the operation
        in_sum = {17'($urandom), $urandom};
        in_sign = 1'($urandom); in_eff_sub = 1'($urandom); in_sticky = 1'($urandom);
        in_exp = 10'($urandom); in_rm = 3'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: latency on each rising out_valid, result/flags on each handshake
    initial begin
        logic        prev_v;
        logic [36:0] e;
        int          a;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_valid: out_valid=1 with no accepted op, required 0");
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 64'(cyc - a), 64'd2);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_result: got %h with empty scoreboard", out_result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(out_result), 64'(e[31:0]));
                    check("flags", 64'(out_flags), 64'(e[36:32]));
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        logic [63:0] tmp;
        logic [48:0] s;
        logic [9:0]  ex;
        logic [2:0]  rm;
        logic        sg, eff, st;
        int          p, t;

        rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_sign = 1'b0; in_eff_sub = 1'b0;
        in_sticky = 1'b0; in_exp = '0; in_rm = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        rst = 1'b0;
        #1;
        check("first_in_ready", 64'(in_ready), 64'd1);

        // Directed cases with hand-derived expectations
        send(49'h0_800000000000, 0, 0, 0, 10'd127, 3'd0, {5'b00000, 32'h3F800000}, 1);
        send(49'h1_000000000000, 0, 0, 0, 10'd127, 3'd0, {5'b00000, 32'h40000000}, 1);
        send(49'h1_000000000000, 0, 0, 0, 10'd254, 3'd0, {5'b00101, 32'h7F800000}, 1);
        send(49'h1_000000000000, 0, 0, 0, 10'd254, 3'd1, {5'b00101, 32'h7F7FFFFF}, 1);
        send(49'h0_800000800000, 0, 0, 0, 10'd127, 3'd0, {5'b00001, 32'h3F800000}, 1);
        send(49'h0_800000800000, 0, 0, 0, 10'd127, 3'd3, {5'b00001, 32'h3F800001}, 1);
        send(49'h0_800000800000, 0, 0, 0, 10'd127, 3'd1, {5'b00001, 32'h3F800000}, 1);
        send(49'h0_000000000000, 0, 1, 0, 10'd127, 3'd2, {5'b00000, 32'h80000000}, 1);
        send(49'h0_000000000000, 1, 1, 0, 10'd127, 3'd0, {5'b00000, 32'h00000000}, 1);
        send(49'h0_000000000001, 1, 0, 0, 10'd10,  3'd0, {5'b00011, 32'h80000000}, 1);
        send(49'h0_000000000000, 1, 0, 1, 10'd100, 3'd0, {5'b00011, 32'h80000000}, 1);
        send(49'h0_FFFFFF800000, 0, 0, 0, 10'd127, 3'd0, {5'b00001, 32'h40000000}, 1);
        send(49'h1_000000000000, 1, 0, 0, 10'd254, 3'd2, {5'b00101, 32'hFF800000}, 1);
        send(49'h1_000000000000, 1, 0, 0, 10'd254, 3'd3, {5'b00101, 32'hFF7FFFFF}, 1);
        drain();

        // Backpressure: result held and in_ready low while out_ready=0
        bp_hold = 1'b1;
        repeat (2) @(negedge clk);
        send(49'h1_000000000000, 0, 0, 0, 10'd127, 3'd0, {5'b00000, 32'h40000000}, 1);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", 64'(out_result), 64'h40000000);
            check("bp_flags", 64'(out_flags), 64'd0);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        bp_hold = 1'b0;
        drain();

        // Reset during ROUND discards the operation
        send(49'h0_800000000000, 0, 0, 0, 10'd127, 3'd0, 37'd0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_in_ready", 64'(in_ready), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) begin
            check("postrst_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Randomized operations against the reference model
        for (int n = 0; n < 300; n++) begin
            p = $urandom_range(0, 48);
            tmp = {$urandom, $urandom};
            tmp = (tmp & ((64'd1 << p) - 1)) | (64'd1 << p);
            s = tmp[48:0];
            if ($urandom_range(0, 15) == 0) s = 49'd0;
            case ($urandom_range(0, 3))
                0:       ex = 10'($urandom_range(1, 40));
                1:       ex = 10'($urandom_range(230, 254));
                default: ex = 10'($urandom_range(1, 254));
            endcase
            rm  = 3'($urandom_range(0, 7));
            sg  = 1'($urandom);
            eff = 1'($urandom);
            st  = ($urandom_range(0, 3) == 0);
            send(s, sg, eff, st, ex, rm, ref_model(s, sg, eff, st, ex, rm), 1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
